// File: rtl/tlk2711_pkg.sv
// Shared types and helpers for the TLK2711 TX command generator.
// Holds the command FSM states, the channel-index width helper and length alignment.
package tlk2711_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARB,
        ST_REQ
    } cmdState_e;

    function automatic int chWidth(input int numCh);
        return (numCh > 1) ? $clog2(numCh) : 1;
    endfunction

    // Round up to a power-of-two granule; callers truncate to their length width.
    function automatic logic [31:0] alignLen(input logic [15:0] len, input int alignBytes);
        logic [31:0] mask;
        mask = 32'(alignBytes - 1);
        return (32'(len) + mask) & ~mask;
    endfunction

endpackage

// File: rtl/tlk2711_tx_cmd_gen_if.sv
// Read-command handshake and DMA completion bus between the TX command generator and the DMA.
// The generator uses the master modport, the DMA side uses slave.
interface tlk2711_tx_cmd_gen_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DLEN_WIDTH = 16,
    parameter int NUM_CH     = 4
) ();
    import tlk2711_pkg::*;

    localparam int CH_W = chWidth(NUM_CH);

    logic                             o_rd_cmd_req;
    logic                             i_rd_cmd_ack;
    logic [ADDR_WIDTH+DLEN_WIDTH-1:0] o_rd_cmd_data;
    logic [CH_W-1:0]                  o_rd_cmd_ch;
    logic                             i_dma_rd_last;
    logic [CH_W-1:0]                  i_dma_rd_ch;

    modport master (
        output o_rd_cmd_req,
        output o_rd_cmd_data,
        output o_rd_cmd_ch,
        input  i_rd_cmd_ack,
        input  i_dma_rd_last,
        input  i_dma_rd_ch
    );

    modport slave (
        input  o_rd_cmd_req,
        input  o_rd_cmd_data,
        input  o_rd_cmd_ch,
        output i_rd_cmd_ack,
        output i_dma_rd_last,
        output i_dma_rd_ch
    );

endinterface

// File: rtl/tlk2711_tx_cmd_ch.sv
// Per-channel job state: latched job parameters, remaining body/tail commands,
// next command address and the count of acked-but-unfinished commands.
module tlk2711_tx_cmd_ch
    import tlk2711_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DLEN_WIDTH      = 16,
    parameter int ALIGN_BYTES     = 8,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  softRst_i,
    input  logic                  startEdge_i,
    input  logic [ADDR_WIDTH-1:0] baseAddr_i,
    input  logic [15:0]           bodyLen_i,
    input  logic [15:0]           tailLen_i,
    input  logic [15:0]           bodyNum_i,
    input  logic                  ack_i,
    input  logic                  rdLast_i,
    output logic                  eligible_o,
    output logic [ADDR_WIDTH-1:0] cmdAddr_o,
    output logic [DLEN_WIDTH-1:0] cmdLen_o,
    output logic                  busy_o,
    output logic                  done_o
);

    logic                  busy_q, busy_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DLEN_WIDTH-1:0] bodyLenAl_q, bodyLenAl_d;
    logic [DLEN_WIDTH-1:0] tailLenAl_q, tailLenAl_d;
    logic [15:0]           bodyLeft_q, bodyLeft_d;
    logic                  tailPend_q, tailPend_d;
    logic [3:0]            outst_q, outst_d;
    logic                  done_q, done_d;
    logic                  hasCmd;

    assign hasCmd     = (bodyLeft_q != '0) || tailPend_q;
    assign eligible_o = busy_q && hasCmd && (outst_q < 4'(MAX_OUTSTANDING));
    assign cmdAddr_o  = addr_q;
    assign cmdLen_o   = (bodyLeft_q != '0) ? bodyLenAl_q : tailLenAl_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

    // The tail follows the last body command, so the running address is also the tail address.
    always_comb begin
        busy_d      = busy_q;
        addr_d      = addr_q;
        bodyLenAl_d = bodyLenAl_q;
        tailLenAl_d = tailLenAl_q;
        bodyLeft_d  = bodyLeft_q;
        tailPend_d  = tailPend_q;
        outst_d     = outst_q;
        done_d      = 1'b0;

        if (softRst_i) begin
            busy_d     = 1'b0;
            bodyLeft_d = '0;
            tailPend_d = 1'b0;
            outst_d    = '0;
        end else if (!busy_q) begin
            if (startEdge_i) begin
                busy_d      = 1'b1;
                addr_d      = baseAddr_i;
                bodyLenAl_d = DLEN_WIDTH'(alignLen(bodyLen_i, ALIGN_BYTES));
                tailLenAl_d = DLEN_WIDTH'(alignLen(tailLen_i, ALIGN_BYTES));
                bodyLeft_d  = bodyNum_i;
                tailPend_d  = (tailLen_i != '0);
                outst_d     = '0;
            end
        end else begin
            if (ack_i) begin
                if (bodyLeft_q != '0) begin
                    bodyLeft_d = bodyLeft_q - 16'd1;
                    addr_d     = addr_q + ADDR_WIDTH'(bodyLenAl_q);
                end else begin
                    tailPend_d = 1'b0;
                end
            end
            outst_d = outst_q + 4'(ack_i) - 4'(rdLast_i && (outst_q != '0));
            if (!hasCmd && (outst_q == '0)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= 1'b0;
            addr_q      <= '0;
            bodyLenAl_q <= '0;
            tailLenAl_q <= '0;
            bodyLeft_q  <= '0;
            tailPend_q  <= 1'b0;
            outst_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            addr_q      <= addr_d;
            bodyLenAl_q <= bodyLenAl_d;
            tailLenAl_q <= tailLenAl_d;
            bodyLeft_q  <= bodyLeft_d;
            tailPend_q  <= tailPend_d;
            outst_q     <= outst_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: rtl/tlk2711_tx_cmd_gen.sv
// TLK2711 TX read-command generator: per-channel jobs split into body/tail DMA read
// commands, issued one at a time through a round-robin arbiter and a req/ack FSM.
module tlk2711_tx_cmd_gen
    import tlk2711_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DLEN_WIDTH      = 16,
    parameter int NUM_CH          = 4,
    parameter int ALIGN_BYTES     = 8,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_soft_rst,
    input  logic [NUM_CH-1:0]            i_tx_start,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] i_base_addr,
    input  logic [NUM_CH*16-1:0]         i_body_len,
    input  logic [NUM_CH*16-1:0]         i_tail_len,
    input  logic [NUM_CH*16-1:0]         i_body_num,
    tlk2711_tx_cmd_gen_if.master         rd_if,
    output logic [NUM_CH-1:0]            o_ch_busy,
    output logic [NUM_CH-1:0]            o_ch_done
);

    localparam int CH_W = chWidth(NUM_CH);

    cmdState_e                        state_q, state_d;
    logic [CH_W-1:0]                  rrPtr_q, rrPtr_d;
    logic [CH_W-1:0]                  cmdCh_q, cmdCh_d;
    logic [ADDR_WIDTH+DLEN_WIDTH-1:0] cmdData_q, cmdData_d;
    logic [NUM_CH-1:0]                txStart_q, txStartPrev_q;
    logic [NUM_CH-1:0]                startEdge, chElig, chAck, chLast;
    logic [ADDR_WIDTH-1:0]            chAddr [NUM_CH];
    logic [DLEN_WIDTH-1:0]            chLen  [NUM_CH];
    logic                             grantValid;
    logic [CH_W-1:0]                  grantCh;

    // Start history survives a soft reset so a start level still held high cannot retrigger.
    always_ff @(posedge clk) begin
        if (rst) begin
            txStart_q     <= '0;
            txStartPrev_q <= '0;
        end else begin
            txStart_q     <= i_tx_start;
            txStartPrev_q <= txStart_q;
        end
    end

    assign startEdge = txStart_q & ~txStartPrev_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : gCh
        assign chAck[g]  = (state_q == ST_REQ) && rd_if.i_rd_cmd_ack && (cmdCh_q == CH_W'(g));
        assign chLast[g] = rd_if.i_dma_rd_last && (rd_if.i_dma_rd_ch == CH_W'(g));

        tlk2711_tx_cmd_ch #(
            .ADDR_WIDTH      (ADDR_WIDTH),
            .DLEN_WIDTH      (DLEN_WIDTH),
            .ALIGN_BYTES     (ALIGN_BYTES),
            .MAX_OUTSTANDING (MAX_OUTSTANDING)
        ) uCh (
            .clk         (clk),
            .rst         (rst),
            .softRst_i   (i_soft_rst),
            .startEdge_i (startEdge[g]),
            .baseAddr_i  (i_base_addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
            .bodyLen_i   (i_body_len[g*16 +: 16]),
            .tailLen_i   (i_tail_len[g*16 +: 16]),
            .bodyNum_i   (i_body_num[g*16 +: 16]),
            .ack_i       (chAck[g]),
            .rdLast_i    (chLast[g]),
            .eligible_o  (chElig[g]),
            .cmdAddr_o   (chAddr[g]),
            .cmdLen_o    (chLen[g]),
            .busy_o      (o_ch_busy[g]),
            .done_o      (o_ch_done[g])
        );
    end

    // Search starts one past the last granted channel and wraps.
    always_comb begin
        int idx;
        grantValid = 1'b0;
        grantCh    = '0;
        idx        = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(rrPtr_q) + k) % NUM_CH;
            if (!grantValid && chElig[idx]) begin
                grantValid = 1'b1;
                grantCh    = CH_W'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rrPtr_d   = rrPtr_q;
        cmdCh_d   = cmdCh_q;
        cmdData_d = cmdData_q;

        if (i_soft_rst) begin
            state_d = ST_IDLE;
            rrPtr_d = CH_W'(NUM_CH - 1);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|chElig) begin
                        state_d = ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (grantValid) begin
                        state_d   = ST_REQ;
                        rrPtr_d   = grantCh;
                        cmdCh_d   = grantCh;
                        cmdData_d = {chAddr[grantCh], chLen[grantCh]};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (rd_if.i_rd_cmd_ack) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rrPtr_q   <= CH_W'(NUM_CH - 1);
            cmdCh_q   <= '0;
            cmdData_q <= '0;
        end else begin
            state_q   <= state_d;
            rrPtr_q   <= rrPtr_d;
            cmdCh_q   <= cmdCh_d;
            cmdData_q <= cmdData_d;
        end
    end

    assign rd_if.o_rd_cmd_req  = (state_q == ST_REQ);
    assign rd_if.o_rd_cmd_data = cmdData_q;
    assign rd_if.o_rd_cmd_ch   = cmdCh_q;

endmodule

// File: tb/tb_tlk2711_tx_cmd_gen.sv
// Directed bench for tlk2711_tx_cmd_gen: a job table of hand-computed command lists
// plus hand-written sequences for latency, arbitration, limits and resets.
module tb_tlk2711_tx_cmd_gen;

    localparam int ADDR_WIDTH      = 32;
    localparam int DLEN_WIDTH      = 16;
    localparam int NUM_CH          = 4;
    localparam int ALIGN_BYTES     = 8;
    localparam int MAX_OUTSTANDING = 2;
    localparam int NUM_JOBS        = 7;

    typedef struct {
        int          ch;
        logic [31:0] base;
        logic [15:0] body;
        logic [15:0] tail;
        logic [15:0] num;
        int          n;
        logic [31:0] addr [4];
        logic [15:0] len  [4];
    } jobT;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  softRst;
    logic [NUM_CH-1:0]     txStart;
    logic [NUM_CH*32-1:0]  baseAddr;
    logic [NUM_CH*16-1:0]  bodyLen;
    logic [NUM_CH*16-1:0]  tailLen;
    logic [NUM_CH*16-1:0]  bodyNum;
    logic [NUM_CH-1:0]     chBusy;
    logic [NUM_CH-1:0]     chDone;

    int  checkCount = 0;
    int  passCount  = 0;
    jobT jobs [NUM_JOBS];

    tlk2711_tx_cmd_gen_if #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DLEN_WIDTH (DLEN_WIDTH),
        .NUM_CH     (NUM_CH)
    ) rdIf ();

    tlk2711_tx_cmd_gen #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .DLEN_WIDTH      (DLEN_WIDTH),
        .NUM_CH          (NUM_CH),
        .ALIGN_BYTES     (ALIGN_BYTES),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_soft_rst  (softRst),
        .i_tx_start  (txStart),
        .i_base_addr (baseAddr),
        .i_body_len  (bodyLen),
        .i_tail_len  (tailLen),
        .i_body_num  (bodyNum),
        .rd_if       (rdIf),
        .o_ch_busy   (chBusy),
        .o_ch_done   (chDone)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        rdIf.i_dma_rd_last = 1'b0;
    endtask

    task automatic setCh(input int ch, input logic [31:0] base, input logic [15:0] body,
                         input logic [15:0] tail, input logic [15:0] num);
        baseAddr[ch*32 +: 32] = base;
        bodyLen[ch*16 +: 16]  = body;
        tailLen[ch*16 +: 16]  = tail;
        bodyNum[ch*16 +: 16]  = num;
    endtask

    task automatic giveRdLast(input int ch);
        tick();
        rdIf.i_dma_rd_last = 1'b1;
        rdIf.i_dma_rd_ch   = 2'(ch);
    endtask

    // Waits for a request, checks it, optionally stalls the ack, then acks and checks the drop.
    task automatic expectCmd(input int ch, input logic [31:0] addr, input logic [15:0] len,
                             input int hold, input bit giveLast);
        int t = 0;
        while (rdIf.o_rd_cmd_req !== 1'b1 && t < 300) begin
            tick();
            t++;
        end
        checkOutput("cmd req", 64'(rdIf.o_rd_cmd_req), 64'd1);
        if (rdIf.o_rd_cmd_req !== 1'b1) return;
        checkOutput("cmd addr", 64'(rdIf.o_rd_cmd_data[47:16]), 64'(addr));
        checkOutput("cmd len", 64'(rdIf.o_rd_cmd_data[15:0]), 64'(len));
        checkOutput("cmd ch", 64'(rdIf.o_rd_cmd_ch), 64'(ch));
        for (int i = 0; i < hold; i++) begin
            tick();
            checkOutput("req held", 64'(rdIf.o_rd_cmd_req), 64'd1);
            checkOutput("data held", 64'(rdIf.o_rd_cmd_data), {16'd0, addr, len});
        end
        rdIf.i_rd_cmd_ack = 1'b1;
        tick();
        rdIf.i_rd_cmd_ack = 1'b0;
        checkOutput("req drop after ack", 64'(rdIf.o_rd_cmd_req), 64'd0);
        if (giveLast) begin
            rdIf.i_dma_rd_last = 1'b1;
            rdIf.i_dma_rd_ch   = 2'(ch);
        end
    endtask

    task automatic waitDone(input int ch);
        int t = 0;
        while (chDone[ch] !== 1'b1 && t < 300) begin
            tick();
            t++;
        end
        checkOutput("done pulse", 64'(chDone[ch]), 64'd1);
        checkOutput("busy clear at done", 64'(chBusy[ch]), 64'd0);
        tick();
        checkOutput("done one cycle", 64'(chDone[ch]), 64'd0);
    endtask

    task automatic applyStimulus(input jobT j);
        setCh(j.ch, j.base, j.body, j.tail, j.num);
        tick();
        txStart[j.ch] = 1'b1;
        for (int k = 0; k < j.n; k++) begin
            expectCmd(j.ch, j.addr[k], j.len[k], (k == 0) ? 2 : 0, 1'b1);
        end
        waitDone(j.ch);
        txStart[j.ch] = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        jobs[0] = '{ch: 0, base: 32'h0000_1000, body: 16'd870, tail: 16'd100, num: 16'd3, n: 4,
                    addr: '{32'h1000, 32'h1368, 32'h16D0, 32'h1A38},
                    len:  '{16'd872, 16'd872, 16'd872, 16'd104}};
        jobs[1] = '{ch: 1, base: 32'hFFFF_FFF0, body: 16'd16, tail: 16'd0, num: 16'd2, n: 2,
                    addr: '{32'hFFFF_FFF0, 32'h0000_0000, 32'h0, 32'h0},
                    len:  '{16'd16, 16'd16, 16'd0, 16'd0}};
        jobs[2] = '{ch: 3, base: 32'h0000_2000, body: 16'd8, tail: 16'd1, num: 16'd1, n: 2,
                    addr: '{32'h2000, 32'h2008, 32'h0, 32'h0},
                    len:  '{16'd8, 16'd8, 16'd0, 16'd0}};
        jobs[3] = '{ch: 2, base: 32'h0000_3000, body: 16'd0, tail: 16'd5, num: 16'd0, n: 1,
                    addr: '{32'h3000, 32'h0, 32'h0, 32'h0},
                    len:  '{16'd8, 16'd0, 16'd0, 16'd0}};
        jobs[4] = '{ch: 0, base: 32'h0000_4000, body: 16'd7, tail: 16'd0, num: 16'd1, n: 1,
                    addr: '{32'h4000, 32'h0, 32'h0, 32'h0},
                    len:  '{16'd8, 16'd0, 16'd0, 16'd0}};
        jobs[5] = '{ch: 1, base: 32'h0000_0100, body: 16'd65535, tail: 16'd0, num: 16'd1, n: 1,
                    addr: '{32'h0100, 32'h0, 32'h0, 32'h0},
                    len:  '{16'd0, 16'd0, 16'd0, 16'd0}};
        jobs[6] = '{ch: 2, base: 32'h0000_5000, body: 16'd24, tail: 16'd3, num: 16'd2, n: 3,
                    addr: '{32'h5000, 32'h5018, 32'h5030, 32'h0},
                    len:  '{16'd24, 16'd24, 16'd8, 16'd0}};

        rst                = 1'b1;
        softRst            = 1'b0;
        txStart            = '0;
        baseAddr           = '0;
        bodyLen            = '0;
        tailLen            = '0;
        bodyNum            = '0;
        rdIf.i_rd_cmd_ack  = 1'b0;
        rdIf.i_dma_rd_last = 1'b0;
        rdIf.i_dma_rd_ch   = '0;

        // Reset state
        repeat (3) tick();
        checkOutput("reset req", 64'(rdIf.o_rd_cmd_req), 64'd0);
        checkOutput("reset data", 64'(rdIf.o_rd_cmd_data), 64'd0);
        checkOutput("reset ch", 64'(rdIf.o_rd_cmd_ch), 64'd0);
        checkOutput("reset busy", 64'(chBusy), 64'd0);
        checkOutput("reset done", 64'(chDone), 64'd0);
        rst = 1'b0;
        tick();

        // First request latency from an idle FSM
        setCh(3, 32'h0000_8000, 16'd8, 16'd0, 16'd1);
        tick();
        txStart[3] = 1'b1;
        tick();
        checkOutput("lat req c1", 64'(rdIf.o_rd_cmd_req), 64'd0);
        checkOutput("lat busy c1", 64'(chBusy[3]), 64'd0);
        tick();
        checkOutput("lat req c2", 64'(rdIf.o_rd_cmd_req), 64'd0);
        checkOutput("lat busy c2", 64'(chBusy[3]), 64'd1);
        tick();
        checkOutput("lat req c3", 64'(rdIf.o_rd_cmd_req), 64'd0);
        tick();
        checkOutput("lat req c4", 64'(rdIf.o_rd_cmd_req), 64'd1);
        expectCmd(3, 32'h0000_8000, 16'd8, 0, 1'b1);
        waitDone(3);
        txStart[3] = 1'b0;
        tick();

        // Empty job completes without a request
        setCh(1, 32'h0000_4000, 16'd0, 16'd0, 16'd0);
        tick();
        txStart[1] = 1'b1;
        tick();
        checkOutput("empty done c1", 64'(chDone[1]), 64'd0);
        tick();
        checkOutput("empty done c2", 64'(chDone[1]), 64'd0);
        checkOutput("empty busy c2", 64'(chBusy[1]), 64'd1);
        tick();
        checkOutput("empty done c3", 64'(chDone[1]), 64'd1);
        checkOutput("empty busy c3", 64'(chBusy[1]), 64'd0);
        checkOutput("empty no req c3", 64'(rdIf.o_rd_cmd_req), 64'd0);
        tick();
        checkOutput("empty done c4", 64'(chDone[1]), 64'd0);
        checkOutput("empty no req c4", 64'(rdIf.o_rd_cmd_req), 64'd0);
        txStart[1] = 1'b0;
        tick();

        // Two channels started together alternate grants
        setCh(0, 32'h0000_0000, 16'd64, 16'd0, 16'd2);
        setCh(2, 32'h0001_0000, 16'd64, 16'd0, 16'd2);
        tick();
        txStart[0] = 1'b1;
        txStart[2] = 1'b1;
        expectCmd(0, 32'h0000_0000, 16'd64, 0, 1'b0);
        expectCmd(2, 32'h0001_0000, 16'd64, 0, 1'b0);
        expectCmd(0, 32'h0000_0040, 16'd64, 0, 1'b0);
        expectCmd(2, 32'h0001_0040, 16'd64, 0, 1'b0);
        giveRdLast(0);
        giveRdLast(0);
        waitDone(0);
        giveRdLast(2);
        giveRdLast(2);
        waitDone(2);
        txStart[0] = 1'b0;
        txStart[2] = 1'b0;
        tick();

        for (int i = 0; i < NUM_JOBS; i++) begin
            applyStimulus(jobs[i]);
        end

        // Outstanding limit holds requests until data completes
        setCh(1, 32'h0000_6000, 16'd32, 16'd0, 16'd4);
        tick();
        txStart[1] = 1'b1;
        expectCmd(1, 32'h0000_6000, 16'd32, 0, 1'b0);
        expectCmd(1, 32'h0000_6020, 16'd32, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("req low at limit", 64'(rdIf.o_rd_cmd_req), 64'd0);
        end
        giveRdLast(1);
        expectCmd(1, 32'h0000_6040, 16'd32, 0, 1'b0);
        giveRdLast(1);
        expectCmd(1, 32'h0000_6060, 16'd32, 0, 1'b0);
        giveRdLast(1);
        giveRdLast(1);
        waitDone(1);
        txStart[1] = 1'b0;
        tick();

        // Soft reset while a request waits for its ack
        setCh(2, 32'h0000_7000, 16'd8, 16'd0, 16'd2);
        tick();
        txStart[2] = 1'b1;
        for (int t = 0; t < 50 && rdIf.o_rd_cmd_req !== 1'b1; t++) tick();
        checkOutput("req before soft reset", 64'(rdIf.o_rd_cmd_req), 64'd1);
        tick();
        softRst = 1'b1;
        tick();
        softRst = 1'b0;
        checkOutput("soft rst req", 64'(rdIf.o_rd_cmd_req), 64'd0);
        checkOutput("soft rst busy", 64'(chBusy), 64'd0);
        checkOutput("soft rst done", 64'(chDone), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("no done after soft rst", 64'(chDone), 64'd0);
            checkOutput("no req after soft rst", 64'(rdIf.o_rd_cmd_req), 64'd0);
        end
        txStart[2] = 1'b0;
        tick();
        tick();
        txStart[2] = 1'b1;
        expectCmd(2, 32'h0000_7000, 16'd8, 0, 1'b1);
        expectCmd(2, 32'h0000_7008, 16'd8, 0, 1'b1);
        waitDone(2);
        txStart[2] = 1'b0;
        tick();

        // Hard reset aborts a pending request
        setCh(1, 32'h0000_9000, 16'd8, 16'd0, 16'd1);
        tick();
        txStart[1] = 1'b1;
        for (int t = 0; t < 50 && rdIf.o_rd_cmd_req !== 1'b1; t++) tick();
        checkOutput("req before rst", 64'(rdIf.o_rd_cmd_req), 64'd1);
        rst = 1'b1;
        txStart[1] = 1'b0;
        tick();
        checkOutput("rst req", 64'(rdIf.o_rd_cmd_req), 64'd0);
        checkOutput("rst data", 64'(rdIf.o_rd_cmd_data), 64'd0);
        checkOutput("rst ch", 64'(rdIf.o_rd_cmd_ch), 64'd0);
        checkOutput("rst busy", 64'(chBusy), 64'd0);
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
